// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory for the MEM stage of a pipeline. Writes
//   complete in a single cycle. Reads stall the pipeline through mem_busy
//   for READ_LAT+1 cycles, and the registered data is returned in the first
//   cycle that mem_busy is low. Faulting accesses set a sticky error flag
//   and capture the address of the first fault.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : asynchronous, active-high reset
//   ram_addr_mem     : byte address (word index = [31:2])
//   ram_data_mem     : store data
//   ram_read_enable  : read request (held by the MEM stage while stalled)
//   ram_write_enable : write request
//   ram_data         : registered read data
//   mem_busy         : pipeline stall request
//   mem_err          : sticky access-fault flag
//   err_addr         : byte address of the first faulting access
module data_mem_responder #(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned READ_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ram_addr_mem,
   input  logic [31:0] ram_data_mem,
   input  logic        ram_read_enable,
   input  logic        ram_write_enable,
   output logic [31:0] ram_data,
   output logic        mem_busy,
   output logic        mem_err,
   output logic [31:0] err_addr
);

   localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0]  CNT_INIT = 2'(READ_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [IW-1:0]  rd_idx_q, rd_idx_d;
   logic           rd_fault_q, rd_fault_d;
   logic [31:0]    ram_data_q, ram_data_d;
   logic           mem_err_q, mem_err_d;
   logic [31:0]    err_addr_q, err_addr_d;

   logic [31:0]    mem [DEPTH];
   logic           mem_we;

   logic [29:0]    word_idx;
   logic [IW-1:0]  acc_idx;
   logic           access;
   logic           fault;

   assign word_idx = ram_addr_mem[31:2];
   assign acc_idx  = word_idx[IW-1:0];
   assign access   = ram_read_enable | ram_write_enable;
   // Both enables together count as a fault; such an access proceeds as a read.
   assign fault    = (ram_addr_mem[1:0] != 2'b00)
                   | ({2'b00, word_idx} >= DEPTH)
                   | (ram_read_enable & ram_write_enable);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_idx_d   = rd_idx_q;
      rd_fault_d = rd_fault_q;
      ram_data_d = ram_data_q;
      mem_err_d  = mem_err_q;
      err_addr_d = err_addr_q;
      mem_busy   = 1'b0;
      mem_we     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (access && fault && !mem_err_q) begin
               mem_err_d  = 1'b1;
               err_addr_d = ram_addr_mem;
            end
            if (ram_read_enable) begin
               mem_busy   = 1'b1;
               rd_idx_d   = acc_idx;
               rd_fault_d = fault;
               cnt_d      = CNT_INIT;
               state_d    = RD_WAIT;
            end else if (ram_write_enable && !fault) begin
               mem_we = 1'b1;
            end
         end
         RD_WAIT: begin
            mem_busy = 1'b1;
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               ram_data_d = rd_fault_q ? '0 : mem[rd_idx_q];
               state_d    = RD_DONE;
            end
         end
         RD_DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_idx_q   <= '0;
         rd_fault_q <= 1'b0;
         ram_data_q <= '0;
         mem_err_q  <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_idx_q   <= rd_idx_d;
         rd_fault_q <= rd_fault_d;
         ram_data_q <= ram_data_d;
         mem_err_q  <= mem_err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Array kept out of the reset domain so its contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= ram_data_mem;
      end
   end

   assign ram_data = ram_data_q;
   assign mem_err  = mem_err_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Drives four responders (READ_LAT 1..4) with shared stimulus and compares
//   each against a behavioural model: a word array, a sticky error flag and
//   a per-latency timing expectation (busy READ_LAT+1 cycles, data valid in
//   the first non-busy cycle).
module tb_data_mem_responder;

   logic        clk;
   logic        reset;
   logic [31:0] ram_addr_mem;
   logic [31:0] ram_data_mem;
   logic        ram_read_enable;
   logic        ram_write_enable;

   logic [31:0] rdata [4];
   logic        busy  [4];
   logic        err   [4];
   logic [31:0] eaddr [4];

   int errors = 0;
   int checks = 0;

   logic [31:0] m_mem [256];
   bit          m_err;
   logic [31:0] m_eaddr;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      data_mem_responder #(
         .DEPTH    (256),
         .READ_LAT (g + 1)
      ) u_dut (
         .clk              (clk),
         .reset            (reset),
         .ram_addr_mem     (ram_addr_mem),
         .ram_data_mem     (ram_data_mem),
         .ram_read_enable  (ram_read_enable),
         .ram_write_enable (ram_write_enable),
         .ram_data         (rdata[g]),
         .mem_busy         (busy[g]),
         .mem_err          (err[g]),
         .err_addr         (eaddr[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int inst,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[READ_LAT=%0d] observed=%h expected=%h", tag, inst + 1, obs, exp);
      end
   endtask

   function automatic bit is_fault(input logic [31:0] a, input bit r, input bit w);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256) || (r && w);
   endfunction

   function automatic void model_fault(input bit f, input logic [31:0] a);
      if (f && !m_err) begin
         m_err   = 1'b1;
         m_eaddr = a;
      end
   endfunction

   task automatic chk_err(input string tag);
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_err"}, k, 32'(err[k]), 32'(m_err));
         chk({tag, "_eaddr"}, k, eaddr[k], m_eaddr);
      end
   endtask

   // Called at posedge+1; returns at posedge+1.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bit f;
      f = is_fault(a, 1'b0, 1'b1);
      ram_addr_mem     = a;
      ram_data_mem     = d;
      ram_write_enable = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) chk("wr_busy", k, 32'(busy[k]), 32'd0);
      @(posedge clk); #1;
      ram_write_enable = 1'b0;
      if (f) model_fault(f, a);
      else   m_mem[a[9:2]] = d;
      chk_err("wr");
   endtask

   task automatic rd(input logic [31:0] a, input bit both, input bit stray);
      bit          f;
      logic [31:0] exp;
      int          nb [4];
      int          fl [4];
      f = is_fault(a, 1'b1, both);
      model_fault(f, a);
      exp = f ? 32'd0 : m_mem[a[9:2]];
      ram_addr_mem     = a;
      ram_data_mem     = $urandom;
      ram_read_enable  = 1'b1;
      ram_write_enable = both;
      for (int k = 0; k < 4; k++) begin
         nb[k] = 0;
         fl[k] = -1;
      end
      for (int i = 0; i < 7; i++) begin
         #1;
         for (int k = 0; k < 4; k++) begin
            if (busy[k]) nb[k]++;
            else if (fl[k] < 0) fl[k] = i;
            if (i == k + 2) chk("rd_data", k, rdata[k], exp);
         end
         @(posedge clk); #1;
         if (i == 0) begin
            ram_read_enable  = 1'b0;
            ram_write_enable = 1'b0;
            if (stray) begin
               ram_addr_mem     = a ^ 32'h4;
               ram_data_mem     = 32'hBAD0_BAD0;
               ram_write_enable = 1'b1;
            end
         end
         if (i == 1) ram_write_enable = 1'b0;
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rd_busy_cycles", k, 32'(nb[k]), 32'(k + 2));
         chk("rd_first_idle", k, 32'(fl[k]), 32'(k + 2));
         chk("rd_hold", k, rdata[k], exp);
      end
      chk_err("rd");
   endtask

   // Read held high continuously: each read repeats with period READ_LAT+2.
   task automatic b2b(input logic [31:0] a);
      logic [31:0] exp;
      int          bad [4];
      int          ph;
      exp = m_mem[a[9:2]];
      ram_addr_mem    = a;
      ram_read_enable = 1'b1;
      for (int k = 0; k < 4; k++) bad[k] = 0;
      for (int i = 0; i < 24; i++) begin
         #1;
         for (int k = 0; k < 4; k++) begin
            ph = i % (k + 3);
            if (busy[k] !== (ph <= k + 1)) bad[k]++;
            if (ph == k + 2 && rdata[k] !== exp) bad[k]++;
         end
         @(posedge clk); #1;
      end
      ram_read_enable = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) chk("b2b_bad_cycles", k, 32'(bad[k]), 32'd0);
   endtask

   task automatic rst_mid();
      ram_addr_mem    = 32'h10;
      ram_read_enable = 1'b1;
      @(posedge clk); #1;
      ram_read_enable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_busy", k, 32'(busy[k]), 32'd0);
         chk("rst_data", k, rdata[k], 32'd0);
         chk("rst_err", k, 32'(err[k]), 32'd0);
         chk("rst_eaddr", k, eaddr[k], 32'd0);
      end
      m_err   = 1'b0;
      m_eaddr = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_no_update", k, rdata[k], 32'd0);
         chk("rst_idle_busy", k, 32'(busy[k]), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] a;
      reset            = 1'b1;
      ram_addr_mem     = '0;
      ram_data_mem     = '0;
      ram_read_enable  = 1'b0;
      ram_write_enable = 1'b0;
      m_err            = 1'b0;
      m_eaddr          = '0;
      #2;
      for (int k = 0; k < 4; k++) begin
         chk("reset_data", k, rdata[k], 32'd0);
         chk("reset_busy", k, 32'(busy[k]), 32'd0);
         chk("reset_err", k, 32'(err[k]), 32'd0);
         chk("reset_eaddr", k, eaddr[k], 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;

      // First request lands in the first cycle after release.
      for (int i = 0; i < 16; i++) wr(32'(i) << 2, $urandom);
      rd(32'h0, 1'b0, 1'b0);

      // Write then immediate read of the same word.
      wr(32'h10, 32'hDEADBEEF);
      rd(32'h10, 1'b0, 1'b0);

      // Misaligned write: no update, first fault captured.
      wr(32'h13, 32'h1234_5678);
      for (int k = 0; k < 4; k++) chk("misalign_eaddr", k, eaddr[k], 32'h13);
      rd(32'h10, 1'b0, 1'b0);
      wr(32'h2001, 32'hFFFF_FFFF);
      for (int k = 0; k < 4; k++) chk("sticky_eaddr", k, eaddr[k], 32'h13);

      // Out-of-range read.
      rd(32'h400, 1'b0, 1'b0);

      // Both enables: faulting read, no write.
      wr(32'h8, 32'h55);
      rd(32'h8, 1'b1, 1'b0);
      rd(32'h8, 1'b0, 1'b0);

      // Stray write during a read is ignored.
      rd(32'h10, 1'b0, 1'b1);
      rd(32'h14, 1'b0, 1'b0);

      // Reset mid-read; memory survives.
      rst_mid();
      rd(32'h10, 1'b0, 1'b0);

      // Back-to-back reads, held and discrete.
      b2b(32'h4);
      rd(32'h0, 1'b0, 1'b0);
      rd(32'h4, 1'b0, 1'b0);

      // Randomized mix.
      for (int n = 0; n < 40; n++) begin
         a = 32'($urandom_range(0, 15)) << 2;
         case ($urandom_range(0, 5))
            0, 1: wr(a, $urandom);
            2, 3: rd(a, 1'b0, 1'b0);
            4:    rd(a, 1'b0, 1'b1);
            default: begin
               if ($urandom_range(0, 1) == 0) wr(a | 32'(($urandom_range(1, 3))), $urandom);
               else rd(a | 32'h800, 1'b0, 1'b0);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit data words.
REQ-002 SHALL have parameter READ_LAT, default 2: read wait cycles; legal range 1..4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ram_addr_mem, input, 32 bits: byte address from the MEM stage.
REQ-006 SHALL have port ram_data_mem, input, 32 bits: store data from the MEM stage.
REQ-007 SHALL have port ram_read_enable, input, 1 bit: read request, held by the MEM stage while stalled.
REQ-008 SHALL have port ram_write_enable, input, 1 bit: write request.
REQ-009 SHALL have port ram_data, output, 32 bits: registered read data returned to the MEM stage.
REQ-010 SHALL have port mem_busy, output, 1 bit: pipeline stall request.
REQ-011 SHALL have port mem_err, output, 1 bit: sticky access-fault flag.
REQ-012 SHALL have port err_addr, output, 32 bits: byte address of the first faulting access.

Function
REQ-013 SHALL implement states IDLE, RD_WAIT and RD_DONE, plus a 2-bit wait counter cnt.
REQ-014 SHALL address memory by word index ram_addr_mem[31:2].
REQ-015 SHALL treat an access as faulting when ram_addr_mem[1:0] != 0, or the word index >= DEPTH, or both enables are high.
REQ-016 IDLE with write only and no fault: mem[index] <= ram_data_mem at the clock edge; mem_busy stays 0; state stays IDLE.
REQ-017 IDLE with read only: mem_busy = 1 combinationally in the same cycle; the address is latched; cnt <= READ_LAT-1; next state RD_WAIT.
REQ-018 RD_WAIT: mem_busy = 1; if cnt != 0, cnt decrements.
REQ-019 RD_WAIT with cnt == 0: ram_data <= mem[latched index] (or 0 if the read faulted); next state RD_DONE.
REQ-020 RD_DONE: mem_busy = 0 and ram_data is valid; the next edge returns to IDLE unconditionally, whatever the enables are.
REQ-021 Read timing: mem_busy SHALL be high for exactly READ_LAT+1 consecutive cycles, and data SHALL be valid in the first cycle with mem_busy low.
REQ-022 Outside RD_DONE, ram_data SHALL hold its last loaded value.
REQ-023 IDLE with neither enable high: no state change; mem_busy = 0.
REQ-024 Both enables high: no memory write; treated as a faulting read (full latency, returns 0).
REQ-025 Faulting write: memory SHALL be unchanged; mem_busy SHALL stay 0.
REQ-026 Faulting read: full READ_LAT timing SHALL apply and ram_data SHALL load 0.
REQ-027 On any fault with mem_err == 0: mem_err <= 1 and err_addr <= ram_addr_mem at the edge that ends the faulting IDLE cycle.
REQ-028 Later faults SHALL NOT update err_addr.
REQ-029 Enables arriving in RD_WAIT or RD_DONE SHALL be ignored; in particular no write occurs.
REQ-030 Read-after-write to the same index in consecutive cycles SHALL return the newly written data.
REQ-031 Back-to-back reads SHALL each incur the full latency; the RD_DONE -> IDLE step re-arms the responder.

Reset
REQ-032 Reset asserted SHALL immediately force: state IDLE, cnt 0, ram_data 0, mem_busy 0, mem_err 0, err_addr 0.
REQ-033 Reset during RD_WAIT or RD_DONE SHALL abort the read with no data update after release.
REQ-034 Memory array contents SHALL NOT be cleared by reset.
REQ-035 First request SHALL be accepted in the first cycle after reset deassertion.

Verification
REQ-036 Write-then-read, READ_LAT=2: write 0xDEADBEEF to 0x10; next cycle read 0x10 -> mem_busy high 3 cycles; ram_data = 0xDEADBEEF in cycle 4 with mem_busy 0.
REQ-037 Misaligned write to 0x13 -> mem[4] unchanged, mem_err = 1, err_addr = 0x13; a later fault at 0x2001 leaves err_addr = 0x13.
REQ-038 Out-of-range read at 0x400 (DEPTH=256) -> busy 3 cycles; ram_data = 0; mem_err = 1.
REQ-039 Both enables high at 0x8 holding 0x55 -> mem[2] stays 0x55; busy READ_LAT+1 cycles; ram_data = 0.
REQ-040 Reset pulse in the second RD_WAIT cycle -> immediately IDLE, busy 0, ram_data 0; previously written word still readable afterwards.
REQ-041 Sweep READ_LAT 1..4 with back-to-back reads of 0x0 and 0x4 -> each read busy READ_LAT+1 cycles; correct data per read.
